// File: rtl/im_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : im_loader_if
//  Purpose  : Bundles the byte-stream input, load-request and instruction-
//             memory write signals of the instruction-memory loader.
//
//  Signals  :
//    start       request a load (sampled only while the loader is idle)
//    base_addr   byte address of the first word (sampled with start)
//    word_count  number of 32-bit words to load (sampled with start)
//    byte_valid  source presents a byte on byte_data
//    byte_data   stream byte
//    byte_ready  loader accepts a byte this cycle
//    im_we       instruction-memory write strobe, one cycle per word
//    im_addr     byte address of the word being written
//    im_wdata    word being written
//    busy        loader is not idle
//    done        one-cycle pulse at the end of a successful load
//    err         one-cycle pulse when a start request is rejected
//
//  Modports :
//    master  request/stream source (drives start, parameters and bytes)
//    slave   the loader itself
//
//  Revision : 1.0  initial release
// ============================================================================
interface im_loader_if;
  logic        start;
  logic [31:0] base_addr;
  logic [10:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start,
    output base_addr,
    output word_count,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  im_we,
    input  im_addr,
    input  im_wdata,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  base_addr,
    input  word_count,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output im_we,
    output im_addr,
    output im_wdata,
    output busy,
    output done,
    output err
  );
endinterface
`default_nettype wire

// File: rtl/im_loader.sv
`default_nettype none
// ============================================================================
//  Module   : im_loader
//  Purpose  : Receives a byte stream (valid/ready), packs every four bytes
//             MSB first into a 32-bit word and writes the words into an
//             instruction memory at consecutive word addresses starting at
//             a latched base address.  Load requests that are misaligned,
//             empty, or that would run past the end of the memory are
//             rejected with an err pulse.
//
//  Ports    :
//    clk       rising-edge clock for all state
//    reset_n   asynchronous active-low reset
//    bus       im_loader_if.slave (request, byte stream, memory write port)
//
//  Parameters:
//    DEPTH_WORDS  instruction-memory depth in 32-bit words (max 1024)
//
//  Revision : 1.0  initial release
// ============================================================================
module im_loader #(
  parameter int DEPTH_WORDS = 1024
) (
  input  wire logic  clk,
  input  wire logic  reset_n,
  im_loader_if.slave bus
);

  localparam logic [31:0] c_DEPTH = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_base;
  logic [10:0] r_count;
  logic [10:0] r_index;
  logic [1:0]  r_bcnt;
  // The first three bytes of a word; the fourth arrives on the write edge
  // and is concatenated straight into the output register.
  logic [23:0] r_shift;

  logic        r_byte_ready;
  logic        r_busy;
  logic        r_im_we;
  logic        r_done;
  logic        r_err;
  logic [31:0] r_im_addr;
  logic [31:0] r_im_wdata;

  // --------------------------------------------------------------------------
  // Start-request validation.  The end index is formed at 12 bits so that a
  // base word index near the top of memory plus a large count cannot wrap
  // and sneak past the depth check.
  // --------------------------------------------------------------------------
  logic [11:0] w_end_index;
  logic        w_misaligned;
  logic        w_empty;
  logic        w_overflow;
  logic        w_bad_req;

  assign w_end_index  = {2'b00, bus.base_addr[11:2]} + {1'b0, bus.word_count};
  assign w_misaligned = (bus.base_addr[1:0] != 2'b00);
  assign w_empty      = (bus.word_count == 11'd0);
  assign w_overflow   = ({20'd0, w_end_index} > c_DEPTH);
  assign w_bad_req    = w_misaligned | w_empty | w_overflow;

  // --------------------------------------------------------------------------
  // Datapath helpers.  The index never exceeds word_count-1 < DEPTH_WORDS,
  // so index+1 always fits in 11 bits (1024 is the largest value needed).
  // --------------------------------------------------------------------------
  logic [10:0] w_index_nxt;
  logic        w_last_word;
  logic [31:0] w_wr_addr;

  assign w_index_nxt = r_index + 11'd1;
  assign w_last_word = (w_index_nxt == r_count);
  assign w_wr_addr   = r_base + {19'd0, r_index, 2'b00};

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.  byte_ready and busy are updated
  // together with the state so they always mirror it exactly.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_base       <= 32'd0;
      r_count      <= 11'd0;
      r_index      <= 11'd0;
      r_bcnt       <= 2'd0;
      r_shift      <= 24'd0;
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_im_we      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_im_addr    <= 32'd0;
      r_im_wdata   <= 32'd0;
    end else begin
      // Pulse outputs default low; im_addr/im_wdata hold between writes.
      r_im_we <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_bad_req) begin
              // Rejected: stay idle, never touch the memory port.
              r_err <= 1'b1;
            end else begin
              r_base       <= bus.base_addr;
              r_count      <= bus.word_count;
              r_index      <= 11'd0;
              r_bcnt       <= 2'd0;
              r_state      <= S_RECV;
              r_byte_ready <= 1'b1;
              r_busy       <= 1'b1;
            end
          end
        end

        S_RECV: begin
          // Ready is high throughout RECV, so valid alone qualifies a beat.
          if (bus.byte_valid) begin
            r_shift <= {r_shift[15:0], bus.byte_data};
            if (r_bcnt == 2'd3) begin
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_im_we      <= 1'b1;
              r_im_addr    <= w_wr_addr;
              r_im_wdata   <= {r_shift, bus.byte_data};
            end else begin
              r_bcnt <= r_bcnt + 2'd1;
            end
          end
        end

        S_WRITE: begin
          r_index <= w_index_nxt;
          r_bcnt  <= 2'd0;
          if (w_last_word) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state      <= S_RECV;
            r_byte_ready <= 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.busy       = r_busy;
  assign bus.im_we      = r_im_we;
  assign bus.im_addr    = r_im_addr;
  assign bus.im_wdata   = r_im_wdata;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the instruction-memory depth in 32-bit words.
REQ-002 SHALL use one clock; reset is asynchronous and active-low; ports are named clk and reset_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  single-cycle request to begin a load; sampled only in IDLE.
REQ-006 base_addr  input  32  byte address of the first word; sampled with start.
REQ-007 word_count  input  11  number of words to load; sampled with start.
REQ-008 byte_valid  input  1  source has a byte on byte_data.
REQ-009 byte_data  input  8  stream byte.
REQ-010 byte_ready  output  1  loader accepts a byte this cycle.
REQ-011 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-012 im_addr  output  32  byte address of the word written; memory indexes it with bits [11:2].
REQ-013 im_wdata  output  32  word written.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at the end of a successful load.
REQ-016 err  output  1  one-cycle pulse when start is rejected.

Function
REQ-017 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-018 A byte SHALL transfer only on a rising edge where byte_valid=1 and byte_ready=1.
REQ-019 byte_ready SHALL be 1 exactly when the state is RECV, with no dependence on byte_valid.
REQ-020 In IDLE, start=1 with valid parameters SHALL latch base_addr and word_count, clear the word index and byte count, and enter RECV on the next edge.
REQ-021 Parameters are invalid, and SHALL be rejected, if any of the following holds: base_addr[1:0]!=0; word_count==0; base_addr[11:2]+word_count>DEPTH_WORDS.
REQ-022 A rejected start SHALL pulse err in the next cycle and stay in IDLE; it SHALL NOT raise im_we or busy.
REQ-023 Start pulses received outside IDLE SHALL be ignored.
REQ-024 Bytes SHALL be packed MSB first: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0].
REQ-025 The edge that accepts byte 3 SHALL move the state to WRITE.
REQ-026 In WRITE, the block SHALL drive, for one cycle, im_we=1, im_addr=latched base+4*index and im_wdata=assembled word.
REQ-027 Leaving WRITE, the block SHALL increment the index, clear the byte count, and go to DONE if index+1==word_count, otherwise to RECV.
REQ-028 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-029 Latency:
  - acceptance of byte 3 on edge N gives im_we high during cycle N+1;
  - for the last word, done is high during cycle N+2.
REQ-030 Peak throughput SHALL be one word per 5 cycles, and the block SHALL tolerate byte_valid gaps of any length.
REQ-031 Outside WRITE, im_we SHALL be 0 and im_wdata/im_addr SHALL hold their last values.
REQ-032 The index SHALL NOT wrap; REQ-021 guarantees every written word index is below DEPTH_WORDS.

Reset
REQ-033 On reset_n=0, the block SHALL go to IDLE and clear the following without waiting for a clock edge:
  - byte_ready, im_we, busy, done, err, im_addr and im_wdata to 0;
  - the index and byte count to 0.
REQ-034 A reset during RECV or WRITE SHALL discard the partial word; no im_we SHALL occur until a new valid start.
REQ-035 Release of reset_n SHALL be followed by operation starting on the first rising clk edge after release.

Verification
REQ-036 Single-word load: start, base=0x0000_0000, count=1, bytes 0x24,0x08,0x00,0x05 back-to-back -> im_we for exactly one cycle with addr=0x0, wdata=0x24080005; done one cycle later.
REQ-037 Multi-word load with gaps: base=0x0000_0010, count=3, random byte_valid idle cycles -> three im_we pulses at 0x10, 0x14, 0x18 with the correct words, a single done, and busy deasserted after done.
REQ-038 Rejection:
  - base=0x0000_0002 -> err pulse;
  - count=0 -> err pulse;
  - base=0x0000_0FFC with count=2 -> err pulse;
  - in all three cases there is no im_we, busy stays 0, and byte_ready stays 0.
REQ-039 Boundary: base=0, count=1024 -> 1024 writes, the last at 0x0000_0FFC, then done.
REQ-040 Reset mid-word: assert reset_n=0 after 2 bytes of a word -> outputs zero immediately and no write occurs; a fresh load then writes correctly from byte 0.
REQ-041 Start while busy: pulse start during RECV -> it is ignored and the original load completes unchanged.
